gen_sequencer: RTL and testbench
================================

Name: gen_sequencer

Overview:
- Parametrised generation sequencer for the Life pipeline. It starts N agents (logic engine, renderer, optional stats/IO units) each generation.
- It collects their done pulses, requests a double-buffer swap, and waits for the buffer controller's ready before starting the next generation.
- Adds run/pause/single-step modes, optional lock to the video frame tick, a per-agent enable mask, a generation counter and a watchdog timeout.

Parameters:
- NUM_AGENTS, 2, number of start/done channel pairs (1..8).
- GEN_W, 16, width of generation counter.
- TIMEOUT_CYCLES, 0, max cycles in RUN before abort; 0 disables the watchdog.
- SYNC_TO_FRAME, 1, 1 = a launch also requires a pending frame tick.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- mode_in  in  2  0 = PAUSE, 1 = RUN, 2 = STEP, 3 = reserved (treated as PAUSE).
- step_in  in  1  single-cycle pulse; requests one generation in STEP mode.
- frame_tick_in  in  1  single-cycle pulse per video frame (vsync).
- agent_mask_in  in  NUM_AGENTS  1 = agent participates.
- done_in  in  NUM_AGENTS  single-cycle done pulse per agent.
- buf_ready_in  in  1  buffer controller has completed or accepted the swap.
- start_out  out  NUM_AGENTS  single-cycle start pulse per agent.
- buf_swap_out  out  1  swap request, level.
- gen_count_out  out  GEN_W  completed generations.
- busy_out  out  1  state != IDLE.
- timeout_out  out  1  sticky watchdog flag.

Behaviour:
- Reset: rst_n_in low asynchronously forces all outputs to 0, state IDLE, and clears the done latches, step_pending, tick_pending, timer and mask_snap. Reset mid-generation abandons the generation; gen_count is not advanced.
- State machine, registered outputs: IDLE -> RUN -> SWAP -> IDLE.
- Pending latches:
  - step_pending sets on step_in in any state and clears on launch.
  - tick_pending sets on frame_tick_in in any state and clears on launch.
  - Multiple pulses collapse to one.
- Launch condition, evaluated in IDLE: agent_mask_in != 0, AND (mode == RUN OR (mode == STEP AND step_pending)), AND (SYNC_TO_FRAME == 0 OR tick_pending).
- On launch:
  - Capture mask_snap = agent_mask_in.
  - Drive start_out = mask_snap for exactly one cycle; start_out is high in the cycle after the launch edge.
  - Clear the done latches and timer, and enter RUN.
- A same-cycle step_in or frame_tick_in counts toward the launch condition, since the latch is OR'd with the input.
- RUN:
  - done_latch |= done_in & mask_snap.
  - When (done_latch | (done_in & mask_snap)) == mask_snap, enter SWAP; buf_swap_out goes high the next cycle.
  - done_in on unmasked channels is ignored. done_in in IDLE or SWAP is ignored.
  - A done arriving in the same cycle as start_out is counted.
- SWAP:
  - Hold buf_swap_out high until buf_ready_in is sampled high while buf_swap_out is high.
  - In that cycle, drop buf_swap_out, increment gen_count (wraps modulo 2^GEN_W), and return to IDLE.
  - buf_ready_in while buf_swap_out is low is ignored.
- Latency with all agents done at cycle t and buf_ready_in already high:
  - buf_swap_out high at t+1.
  - gen_count updated and buf_swap_out low at t+2.
  - Next start_out at t+3, if the launch condition holds.
- Mode changes take effect only in IDLE. A generation in flight always completes, including its swap. PAUSE during RUN stops after the swap.
- agent_mask_in changes during RUN or SWAP have no effect until the next launch.
- Watchdog, when TIMEOUT_CYCLES > 0:
  - The timer counts cycles in RUN.
  - When timer == TIMEOUT_CYCLES - 1 and the mask is not yet complete: set timeout_out (sticky until reset), clear the latches, return to IDLE, no swap, gen_count unchanged.
  - Completion in the same cycle as the timeout wins: go to SWAP, no flag.
  - The timer width is clog2 of TIMEOUT_CYCLES + 1.

Decomposition:
- Package gen_seq_pkg: state_t enum (IDLE, RUN, SWAP), mode_t enum (MODE_PAUSE, MODE_RUN, MODE_STEP), MAX_AGENTS = 8 constant.
- Sub-module gen_watchdog holds the RUN timer, with inputs clear/enable and a single-cycle expire output. It is instantiated only when TIMEOUT_CYCLES > 0; otherwise expire is tied to 0.

Test Plan:
1. NUM_AGENTS = 2, SYNC_TO_FRAME = 0, mode RUN, mask 2'b11, buf_ready_in tied high:
   - Stimulus: done[0] at 5 cycles after start, done[1] at 9 cycles after start.
   - Response: buf_swap_out 1 cycle after done[1]; gen_count 0 -> 1; next start_out = 2'b11 3 cycles after done[1]. Repeat 4 generations; gen_count = 4.
2. Simultaneous and same-cycle dones, mask 2'b11:
   - Stimulus: done = 2'b11 in the same cycle as start_out.
   - Response: immediate SWAP. A done[1] in IDLE produces no effect.
3. Mask 2'b01:
   - Stimulus: only done[0] arrives.
   - Response: completes. Toggling mask to 2'b10 during RUN does not change completion. mask = 0 in IDLE holds IDLE with no start_out.
4. STEP mode, SYNC_TO_FRAME = 1:
   - Stimulus: two step_in pulses in RUN, then a frame_tick.
   - Response: exactly one launch after the current swap, and only after the tick. No further start_out without a new step_in.
5. Backpressure:
   - Stimulus: buf_ready_in low for 20 cycles after buf_swap_out rises.
   - Response: buf_swap_out held 20+ cycles; gen_count increments once, on the ready cycle.
6. TIMEOUT_CYCLES = 50, done[1] never arrives:
   - Response: timeout_out = 1 at RUN cycle 50; returns to IDLE with no buf_swap_out and gen_count unchanged.
   - Stimulus: assert rst_n_in low mid-RUN.
   - Response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gen_seq_pkg.sv
// gen_seq_pkg: shared types and helpers for the generation sequencer.
// Exports state_t, mode_t, MAX_AGENTS and the mode/step launch qualifier.
package gen_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SWAP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_PAUSE = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_STEP  = 2'd2
    } mode_t;

    localparam int unsigned MAX_AGENTS = 8;

    // Mode 3 is reserved and falls through as PAUSE.
    function automatic logic mode_go(
        input logic [1:0] mode,
        input logic       step_pend
    );
        logic go;
        go = 1'b0;
        unique case (1'b1)
            (mode == MODE_RUN):  go = 1'b1;
            (mode == MODE_STEP): go = step_pend;
            default:             go = 1'b0;
        endcase
        return go;
    endfunction

endpackage

// File: rtl/gen_sequencer_watchdog.sv
// gen_watchdog: counts RUN cycles and pulses expire on the last allowed one.
// Ports: clk_i, rst_ni, clear_i (restart), enable_i (in RUN) -> expire_o.
module gen_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 50
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Saturate at LAST so a held enable never wraps back to zero.
    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (enable_i && (timer_q != LAST)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire_o = enable_i && (timer_q == LAST);

endmodule

// File: rtl/gen_sequencer.sv
// gen_sequencer: launches agents each generation, collects dones, swaps buffers.
// Ports: mode/step/frame_tick/mask/done/buf_ready in; start/swap/gen_count/busy/timeout out.
module gen_sequencer
    import gen_seq_pkg::*;
#(
    parameter int unsigned NUM_AGENTS     = 2,
    parameter int unsigned GEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter bit          SYNC_TO_FRAME  = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [1:0]            mode_in,
    input  logic                  step_in,
    input  logic                  frame_tick_in,
    input  logic [NUM_AGENTS-1:0] agent_mask_in,
    input  logic [NUM_AGENTS-1:0] done_in,
    input  logic                  buf_ready_in,
    output logic [NUM_AGENTS-1:0] start_out,
    output logic                  buf_swap_out,
    output logic [GEN_W-1:0]      gen_count_out,
    output logic                  busy_out,
    output logic                  timeout_out
);

    state_t state_q;
    state_t state_d;

    logic [NUM_AGENTS-1:0] mask_snap_q;
    logic [NUM_AGENTS-1:0] mask_snap_d;
    logic [NUM_AGENTS-1:0] done_latch_q;
    logic [NUM_AGENTS-1:0] done_latch_d;
    logic [NUM_AGENTS-1:0] start_q;
    logic [NUM_AGENTS-1:0] start_d;
    logic                  step_pend_q;
    logic                  step_pend_d;
    logic                  tick_pend_q;
    logic                  tick_pend_d;
    logic                  swap_q;
    logic                  swap_d;
    logic [GEN_W-1:0]      gen_q;
    logic [GEN_W-1:0]      gen_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  to_q;
    logic                  to_d;

    logic                  step_eff;
    logic                  tick_eff;
    logic                  frame_ok;
    logic                  launch;
    logic [NUM_AGENTS-1:0] done_hit;
    logic                  complete;
    logic                  swap_ack;
    logic                  expire;

    // Same-cycle pulses count toward the launch they coincide with.
    assign step_eff = step_pend_q | step_in;
    assign tick_eff = tick_pend_q | frame_tick_in;
    assign frame_ok = (SYNC_TO_FRAME == 1'b0) || tick_eff;

    assign launch = (state_q == IDLE)
                 && (|agent_mask_in)
                 && mode_go(mode_in, step_eff)
                 && frame_ok;

    assign done_hit = done_in & mask_snap_q;
    assign complete = ((done_latch_q | done_hit) == mask_snap_q);
    assign swap_ack = swap_q & buf_ready_in;

    if (TIMEOUT_CYCLES > 0) begin : g_wd
        gen_watchdog #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_wd (
            .clk_i    (clk_in),
            .rst_ni   (rst_n_in),
            .clear_i  (launch),
            .enable_i (state_q == RUN),
            .expire_o (expire)
        );
    end else begin : g_no_wd
        assign expire = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion is checked before expiry so a last-cycle finish still swaps.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (complete) begin
                    state_d = SWAP;
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            SWAP: begin
                if (swap_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d      = '0;
        swap_d       = swap_q;
        gen_d        = gen_q;
        to_d         = to_q;
        mask_snap_d  = mask_snap_q;
        done_latch_d = done_latch_q;
        step_pend_d  = step_eff;
        tick_pend_d  = tick_eff;

        if (launch) begin
            mask_snap_d  = agent_mask_in;
            start_d      = agent_mask_in;
            done_latch_d = '0;
            step_pend_d  = 1'b0;
            tick_pend_d  = 1'b0;
        end

        if (state_q == RUN) begin
            done_latch_d = done_latch_q | done_hit;
            if (complete) begin
                swap_d = 1'b1;
            end else if (expire) begin
                to_d         = 1'b1;
                done_latch_d = '0;
            end
        end

        if ((state_q == SWAP) && swap_ack) begin
            swap_d = 1'b0;
            gen_d  = gen_q + 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mask_snap_q  <= '0;
            done_latch_q <= '0;
            start_q      <= '0;
            step_pend_q  <= 1'b0;
            tick_pend_q  <= 1'b0;
            swap_q       <= 1'b0;
            gen_q        <= '0;
            busy_q       <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            mask_snap_q  <= mask_snap_d;
            done_latch_q <= done_latch_d;
            start_q      <= start_d;
            step_pend_q  <= step_pend_d;
            tick_pend_q  <= tick_pend_d;
            swap_q       <= swap_d;
            gen_q        <= gen_d;
            busy_q       <= busy_d;
            to_q         <= to_d;
        end
    end

    assign start_out     = start_q;
    assign buf_swap_out  = swap_q;
    assign gen_count_out = gen_q;
    assign busy_out      = busy_q;
    assign timeout_out   = to_q;

endmodule

// File: tb/tb_gen_sequencer.sv
// tb_gen_sequencer: directed bench for gen_sequencer with a per-cycle reference model.
// Frame tick is held high where frame sync should not gate launches.
module tb_gen_sequencer;

    localparam int NA  = 2;
    localparam int GW  = 3;
    localparam int TMO = 50;

    logic          clk;
    logic          rst_n;
    logic [1:0]    mode;
    logic          step;
    logic          tick;
    logic [NA-1:0] mask;
    logic [NA-1:0] done;
    logic          ready;
    logic [NA-1:0] start;
    logic          swap;
    logic [GW-1:0] gen;
    logic          busy;
    logic          tmo;

    int checks;
    int errors;

    gen_sequencer #(
        .NUM_AGENTS     (NA),
        .GEN_W          (GW),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_TO_FRAME  (1'b1)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .mode_in       (mode),
        .step_in       (step),
        .frame_tick_in (tick),
        .agent_mask_in (mask),
        .done_in       (done),
        .buf_ready_in  (ready),
        .start_out     (start),
        .buf_swap_out  (swap),
        .gen_count_out (gen),
        .busy_out      (busy),
        .timeout_out   (tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 generation running, 2 awaiting swap.
    int            m_phase;
    int            m_cyc;
    int            m_gen;
    logic          m_step;
    logic          m_tick;
    logic          m_to;
    logic          e_swap;
    logic [NA-1:0] m_mask;
    logic [NA-1:0] m_got;
    logic [NA-1:0] e_start;
    logic [NA-1:0] got;
    logic          st;
    logic          tk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cyc   = 0;
            m_gen   = 0;
            m_step  = 0;
            m_tick  = 0;
            m_to    = 0;
            e_swap  = 0;
            m_mask  = '0;
            m_got   = '0;
            e_start = '0;
        end else begin
            st      = m_step | step;
            tk      = m_tick | tick;
            e_start = '0;
            if (m_phase == 0) begin
                if (mask != 0 && tk &&
                    (mode == 2'd1 || (mode == 2'd2 && st))) begin
                    m_phase = 1;
                    m_mask  = mask;
                    e_start = mask;
                    m_got   = '0;
                    m_cyc   = 0;
                    st      = 0;
                    tk      = 0;
                end
            end else if (m_phase == 1) begin
                got   = m_got | (done & m_mask);
                m_cyc = m_cyc + 1;
                if (got == m_mask) begin
                    m_phase = 2;
                    e_swap  = 1;
                end else if (m_cyc == TMO) begin
                    m_phase = 0;
                    m_to    = 1;
                end else begin
                    m_got = got;
                end
            end else if (ready) begin
                m_phase = 0;
                e_swap  = 0;
                m_gen   = (m_gen + 1) % (1 << GW);
            end
            m_step = st;
            m_tick = tk;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_start", 32'(start), 32'(e_start));
            chk("cyc_swap", 32'(swap), 32'(e_swap));
            chk("cyc_gen", 32'(gen), 32'(m_gen));
            chk("cyc_busy", 32'(busy), 32'(m_phase != 0));
            chk("cyc_timeout", 32'(tmo), 32'(m_to));
        end
    end

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start == 0 && n < 100);
        checks++;
        if (start == 0) begin
            errors++;
            $display("FAIL wait_start at %0t: got 0 want nonzero", $time);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        mode   = 2'd0;
        step   = 1'b0;
        tick   = 1'b0;
        mask   = '0;
        done   = '0;
        ready  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_swap", 32'(swap), 32'd0);
        chk("rst_gen", 32'(gen), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: staggered dones, four generations back to back
        tick  = 1'b1;
        ready = 1'b1;
        mask  = 2'b11;
        mode  = 2'd1;
        wait_start();
        chk("t1_first_start", 32'(start), 32'd3);
        for (int g = 0; g < 4; g++) begin
            repeat (5) @(negedge clk);
            done = 2'b01;
            @(negedge clk);
            done = 2'b00;
            repeat (3) @(negedge clk);
            done = 2'b10;
            if (g == 3) mode = 2'd0;
            @(negedge clk);
            done = 2'b00;
            chk("t1_swap_hi", 32'(swap), 32'd1);
            @(negedge clk);
            chk("t1_swap_lo", 32'(swap), 32'd0);
            chk("t1_gen", 32'(gen), 32'(g + 1));
            @(negedge clk);
            chk("t1_next_start", 32'(start), (g < 3) ? 32'd3 : 32'd0);
        end

        // 2: both dones in the start cycle, then a stray done in IDLE
        mode = 2'd1;
        wait_start();
        done = 2'b11;
        @(negedge clk);
        done = 2'b00;
        mode = 2'd0;
        chk("t2_swap", 32'(swap), 32'd1);
        @(negedge clk);
        chk("t2_gen", 32'(gen), 32'd5);
        done = 2'b10;
        @(negedge clk);
        done = 2'b00;
        repeat (3) @(negedge clk);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_idle_start", 32'(start), 32'd0);

        // 3: single-agent mask, mask flipped mid-run, then empty mask
        mask = 2'b01;
        mode = 2'd1;
        wait_start();
        chk("t3_start", 32'(start), 32'd1);
        mask = 2'b10;
        repeat (3) @(negedge clk);
        done = 2'b01;
        mode = 2'd0;
        @(negedge clk);
        done = 2'b00;
        chk("t3_swap", 32'(swap), 32'd1);
        @(negedge clk);
        chk("t3_gen", 32'(gen), 32'd6);
        mask = 2'b00;
        mode = 2'd1;
        repeat (6) @(negedge clk);
        chk("t3_nomask_start", 32'(start), 32'd0);
        chk("t3_nomask_busy", 32'(busy), 32'd0);
        mode = 2'd0;

        // 4: step mode gated by the frame tick
        tick = 1'b0;
        mask = 2'b11;
        mode = 2'd1;
        wait_start();
        mode = 2'd2;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        done = 2'b11;
        @(negedge clk);
        done = 2'b00;
        chk("t4_swap", 32'(swap), 32'd1);
        @(negedge clk);
        chk("t4_gen", 32'(gen), 32'd7);
        repeat (6) @(negedge clk);
        chk("t4_no_tick_start", 32'(start), 32'd0);
        chk("t4_no_tick_busy", 32'(busy), 32'd0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("t4_step_start", 32'(start), 32'd3);
        done = 2'b11;
        @(negedge clk);
        done = 2'b00;
        @(negedge clk);
        chk("t4_gen_wrap", 32'(gen), 32'd0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_no_step_start", 32'(start), 32'd0);
        chk("t4_no_step_busy", 32'(busy), 32'd0);
        mode = 2'd0;

        // 5: buffer backpressure for 20 cycles
        tick  = 1'b1;
        ready = 1'b0;
        mode  = 2'd1;
        wait_start();
        done = 2'b11;
        mode = 2'd0;
        @(negedge clk);
        done = 2'b00;
        chk("t5_swap_rise", 32'(swap), 32'd1);
        repeat (19) @(negedge clk);
        chk("t5_swap_held", 32'(swap), 32'd1);
        chk("t5_gen_held", 32'(gen), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        chk("t5_swap_drop", 32'(swap), 32'd0);
        chk("t5_gen", 32'(gen), 32'd1);

        // 6: watchdog with done[1] missing, then async reset mid-run
        mode = 2'd1;
        wait_start();
        mode = 2'd0;
        repeat (2) @(negedge clk);
        done = 2'b01;
        @(negedge clk);
        done = 2'b00;
        repeat (46) @(negedge clk);
        chk("t6_pre_timeout", 32'(tmo), 32'd0);
        chk("t6_pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t6_timeout", 32'(tmo), 32'd1);
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_swap", 32'(swap), 32'd0);
        chk("t6_abort_gen", 32'(gen), 32'd1);
        repeat (3) @(negedge clk);
        chk("t6_sticky", 32'(tmo), 32'd1);
        mode = 2'd1;
        wait_start();
        @(negedge clk);
        chk("t6_busy_before_rst", 32'(busy), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_timeout", 32'(tmo), 32'd0);
        chk("t6_rst_gen", 32'(gen), 32'd0);
        chk("t6_rst_swap", 32'(swap), 32'd0);
        chk("t6_rst_start", 32'(start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start();
        done = 2'b11;
        mode = 2'd0;
        @(negedge clk);
        done = 2'b00;
        chk("t6_recover_swap", 32'(swap), 32'd1);
        @(negedge clk);
        chk("t6_recover_gen", 32'(gen), 32'd1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
